// File: rtl/gate_counter.sv
// Gate-window event counter for the frequency meter: synchronises the gate and
// measured signal, counts events while the gate is open, latches the result.
//
// state | meaning
// IDLE  | waiting for a synchronised gate rising edge
// COUNT | gate open, counting events into cnt_q
// ABORT | counter saturated; range_change_n pulse, then wait for gate low
module gate_counter #(
  parameter int COUNT_W      = 24,
  parameter int UNDER_THRESH = 1000,
  parameter int RC_PULSE     = 4
) (
  input  logic               clk_i,
  input  logic               nRst,
  input  logic               enable_i,
  input  logic               cpx_i,
  input  logic               ref_tick_i,
  input  logic               measure_mode_i,
  output logic [COUNT_W-1:0] result_o,
  output logic               result_mode_o,
  output logic               result_valid_o,
  output logic               ovf_o,
  output logic               under_o,
  output logic               range_change_n_o,
  output logic               busy_o
);

  localparam int RC_W  = $clog2(RC_PULSE + 1);
  localparam int CMP_W = (COUNT_W > 32) ? COUNT_W + 1 : 33;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [RC_W-1:0]    RC_LOAD = RC_W'(RC_PULSE);
  localparam logic [CMP_W-1:0]   THRESH  = CMP_W'(UNDER_THRESH);

  logic en_s1_q, en_s2_q, en_d_q;
  logic cpx_s1_q, cpx_s2_q, cpx_d_q;

  logic [1:0]         state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [RC_W-1:0]    rc_cnt_q, rc_cnt_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               result_mode_q, result_mode_d;
  logic               result_valid_q, result_valid_d;
  logic               ovf_q, ovf_d;
  logic               under_q, under_d;

  logic               en_rise, en_fall, cpx_rise, event_w, at_max;
  logic [COUNT_W-1:0] cnt_inc, final_cnt;

  // Two-stage synchronisers followed by a delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge nRst) begin
    if (!nRst) begin
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
      en_d_q   <= 1'b0;
      cpx_s1_q <= 1'b0;
      cpx_s2_q <= 1'b0;
      cpx_d_q  <= 1'b0;
    end else begin
      en_s1_q  <= enable_i;
      en_s2_q  <= en_s1_q;
      en_d_q   <= en_s2_q;
      cpx_s1_q <= cpx_i;
      cpx_s2_q <= cpx_s1_q;
      cpx_d_q  <= cpx_s2_q;
    end
  end

  assign en_rise  = en_s2_q & ~en_d_q;
  assign en_fall  = ~en_s2_q & en_d_q;
  assign cpx_rise = cpx_s2_q & ~cpx_d_q;

  assign event_w   = mode_q ? ref_tick_i : cpx_rise;
  assign at_max    = (cnt_q == CNT_MAX);
  assign cnt_inc   = cnt_q + COUNT_W'(1);
  assign final_cnt = event_w ? cnt_inc : cnt_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    rc_cnt_d       = rc_cnt_q;
    result_d       = result_q;
    result_mode_d  = result_mode_q;
    result_valid_d = 1'b0;
    ovf_d          = ovf_q;
    under_d        = under_q;

    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
          cnt_d   = '0;
          mode_d  = measure_mode_i;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        // A saturating event beats a coincident gate close: no result is latched.
        if (event_w && at_max) begin
          ovf_d    = 1'b1;
          rc_cnt_d = RC_LOAD;
          state_d  = S_ABORT;
        end else begin
          if (event_w) begin
            cnt_d = cnt_inc;
          end
          if (en_fall) begin
            result_d       = final_cnt;
            result_mode_d  = mode_q;
            under_d        = (CMP_W'(final_cnt) < THRESH);
            ovf_d          = 1'b0;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
          end
        end
      end

      S_ABORT: begin
        if (rc_cnt_q != '0) begin
          rc_cnt_d = rc_cnt_q - RC_W'(1);
        end else if (!en_s2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nRst) begin
    if (!nRst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mode_q         <= 1'b0;
      rc_cnt_q       <= '0;
      result_q       <= '0;
      result_mode_q  <= 1'b0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      under_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      rc_cnt_q       <= rc_cnt_d;
      result_q       <= result_d;
      result_mode_q  <= result_mode_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      under_q        <= under_d;
    end
  end

  assign result_o         = result_q;
  assign result_mode_o    = result_mode_q;
  assign result_valid_o   = result_valid_q;
  assign ovf_o            = ovf_q;
  assign under_o          = under_q;
  assign range_change_n_o = (rc_cnt_q == '0);
  assign busy_o           = (state_q == S_COUNT) || (state_q == S_ABORT);

endmodule

// File: tb/tb_gate_counter.sv
// Bench for gate_counter: a 24-bit and an 8-bit instance share stimulus; results
// are checked against a queue of expected windows.
module tb_gate_counter;

  logic clk = 1'b0;
  logic nRst, enable, cpx, ref_tick, measure_mode;

  logic [23:0] r24;
  logic        rm24, rv24, ovf24, un24, rcn24, busy24;
  logic [7:0]  r8;
  logic        rm8, rv8, ovf8, un8, rcn8, busy8;

  typedef struct packed {
    logic [23:0] res;
    logic        mode;
    logic        under;
  } exp_t;

  exp_t q24[$];
  exp_t q8[$];
  exp_t e24, e8;

  int total = 0;
  int bad   = 0;
  int rc_low8 = 0;
  int last8 = 0;

  always #5 clk = ~clk;

  gate_counter #(.COUNT_W(24), .UNDER_THRESH(1000), .RC_PULSE(4)) dut (
    .clk_i(clk), .nRst(nRst), .enable_i(enable), .cpx_i(cpx), .ref_tick_i(ref_tick),
    .measure_mode_i(measure_mode), .result_o(r24), .result_mode_o(rm24),
    .result_valid_o(rv24), .ovf_o(ovf24), .under_o(un24),
    .range_change_n_o(rcn24), .busy_o(busy24)
  );

  gate_counter #(.COUNT_W(8), .UNDER_THRESH(1000), .RC_PULSE(4)) dut8 (
    .clk_i(clk), .nRst(nRst), .enable_i(enable), .cpx_i(cpx), .ref_tick_i(ref_tick),
    .measure_mode_i(measure_mode), .result_o(r8), .result_mode_o(rm8),
    .result_valid_o(rv8), .ovf_o(ovf8), .under_o(un8),
    .range_change_n_o(rcn8), .busy_o(busy8)
  );

  // Expected window result; the 8-bit instance only reports counts up to 255.
  task automatic push_exp(input int n, input bit mode);
    exp_t e;
    e.res   = 24'(n);
    e.mode  = mode;
    e.under = (n < 1000);
    q24.push_back(e);
    if (n <= 255) begin
      q8.push_back(e);
      last8 = n;
    end
  endtask

  // Opens the gate, produces n cpx rising edges, closes the gate (optionally on the last edge).
  task automatic cpx_window(input int n, input int half, input bit fall_with_last,
                            input bit mode_at_rise, input bit toggle_mode);
    @(negedge clk);
    measure_mode = mode_at_rise;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (half) @(negedge clk);
      cpx = 1'b1;
      if (fall_with_last && i == n - 1) enable = 1'b0;
      if (toggle_mode && i == n / 2) measure_mode = ~measure_mode;
      repeat (half) @(negedge clk);
      cpx = 1'b0;
    end
    if (!fall_with_last) begin
      repeat (2) @(negedge clk);
      enable = 1'b0;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({r24, rm24, rv24, ovf24, un24, rcn24, busy24} !== {24'd0, 6'b000010}) begin
      bad++;
      $display("FAIL reset24 got=%h required=%h", {r24, rm24, rv24, ovf24, un24, rcn24, busy24},
               {24'd0, 6'b000010});
    end
    total++;
    if ({r8, rm8, rv8, ovf8, un8, rcn8, busy8} !== {8'd0, 6'b000010}) begin
      bad++;
      $display("FAIL reset8 got=%h required=%h", {r8, rm8, rv8, ovf8, un8, rcn8, busy8},
               {8'd0, 6'b000010});
    end
    nRst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_freq;
    push_exp(1250, 1'b0);
    cpx_window(1250, 4, 1'b0, 1'b0, 1'b0);
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL freq_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
    total++;
    if (ovf8 !== 1'b1 || ovf24 !== 1'b0) begin
      bad++;
      $display("FAIL freq_ovf ovf8=%b ovf24=%b required 1/0", ovf8, ovf24);
    end
  endtask

  task automatic test_period;
    push_exp(500, 1'b1);
    @(negedge clk);
    ref_tick = 1'b1;
    measure_mode = 1'b1;
    enable = 1'b1;
    repeat (500) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    ref_tick = 1'b0;
    measure_mode = 1'b0;
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL period_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
  endtask

  task automatic test_boundary;
    push_exp(255, 1'b0);
    cpx_window(255, 3, 1'b1, 1'b0, 1'b0);
    total++;
    if (q24.size() != 0 || q8.size() != 0 || ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL bound255 pending24=%0d pending8=%0d ovf8=%b required 0/0/0",
               q24.size(), q8.size(), ovf8);
    end
    rc_low8 = 0;
    push_exp(256, 1'b0);
    cpx_window(256, 3, 1'b1, 1'b0, 1'b0);
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL bound256_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
    total++;
    if (ovf8 !== 1'b1 || r8 !== 8'(last8) || rc_low8 != 4) begin
      bad++;
      $display("FAIL bound256_abort ovf8=%b result8=%0d rc_low=%0d required 1/%0d/4",
               ovf8, r8, rc_low8, last8);
    end
  endtask

  task automatic test_overflow;
    rc_low8 = 0;
    push_exp(300, 1'b0);
    cpx_window(300, 3, 1'b0, 1'b0, 1'b0);
    total++;
    if (rc_low8 != 4) begin
      bad++;
      $display("FAIL ovf_rc_pulse low_cycles=%0d required 4", rc_low8);
    end
    total++;
    if (ovf8 !== 1'b1 || r8 !== 8'(last8) || busy8 !== 1'b0 || rcn24 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_state ovf8=%b result8=%0d busy8=%b rcn24=%b required 1/%0d/0/1",
               ovf8, r8, busy8, rcn24, last8);
    end
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL ovf_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
  endtask

  task automatic test_mode_hold;
    ref_tick = 1'b1;
    push_exp(20, 1'b0);
    cpx_window(20, 3, 1'b0, 1'b0, 1'b1);
    // period mode with ref_tick every clk counts the whole gate length: 20*6+2 clk
    push_exp(122, 1'b1);
    cpx_window(20, 3, 1'b0, 1'b1, 1'b1);
    ref_tick = 1'b0;
    measure_mode = 1'b0;
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL mode_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat (3) @(negedge clk);
      cpx = 1'b1;
      repeat (3) @(negedge clk);
      cpx = 1'b0;
    end
    nRst = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({r24, rm24, rv24, ovf24, un24, rcn24, busy24} !== {24'd0, 6'b000010} ||
        {r8, rm8, rv8, ovf8, un8, rcn8, busy8} !== {8'd0, 6'b000010}) begin
      bad++;
      $display("FAIL reset_mid got24=%h got8=%h required %h/%h",
               {r24, rm24, rv24, ovf24, un24, rcn24, busy24},
               {r8, rm8, rv8, ovf8, un8, rcn8, busy8}, {24'd0, 6'b000010}, {8'd0, 6'b000010});
    end
    nRst = 1'b1;
    repeat (4) @(negedge clk);
    push_exp(17, 1'b0);
    cpx_window(17, 3, 1'b0, 1'b0, 1'b0);
    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_drain pending24=%0d pending8=%0d required 0", q24.size(), q8.size());
    end
  endtask

  task automatic test_back_to_back;
    push_exp(5, 1'b0);
    cpx_window(5, 3, 1'b1, 1'b0, 1'b0);
    push_exp(9, 1'b0);
    cpx_window(9, 3, 1'b0, 1'b0, 1'b0);
    total++;
    if (q24.size() != 0 || q8.size() != 0 || busy24 !== 1'b0) begin
      bad++;
      $display("FAIL b2b pending24=%0d pending8=%0d busy24=%b required 0/0/0",
               q24.size(), q8.size(), busy24);
    end
  endtask

  initial begin
    nRst = 1'b0;
    enable = 1'b0;
    cpx = 1'b0;
    ref_tick = 1'b0;
    measure_mode = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rcn8) rc_low8++;
        if (nRst && rv24) begin
          total++;
          if (q24.size() == 0) begin
            bad++;
            $display("FAIL sb24_unexpected result=%0d required no result_valid", r24);
          end else begin
            e24 = q24.pop_front();
            if (r24 !== e24.res || rm24 !== e24.mode || un24 !== e24.under || ovf24 !== 1'b0) begin
              bad++;
              $display("FAIL sb24 result=%0d mode=%b under=%b ovf=%b required %0d/%b/%b/0",
                       r24, rm24, un24, ovf24, e24.res, e24.mode, e24.under);
            end
          end
        end
        if (nRst && rv8) begin
          total++;
          if (q8.size() == 0) begin
            bad++;
            $display("FAIL sb8_unexpected result=%0d required no result_valid", r8);
          end else begin
            e8 = q8.pop_front();
            if (r8 !== e8.res[7:0] || rm8 !== e8.mode || un8 !== e8.under || ovf8 !== 1'b0) begin
              bad++;
              $display("FAIL sb8 result=%0d mode=%b under=%b ovf=%b required %0d/%b/%b/0",
                       r8, rm8, un8, ovf8, e8.res[7:0], e8.mode, e8.under);
            end
          end
        end
      end
    join_none

    test_reset();
    test_freq();
    test_period();
    test_boundary();
    test_overflow();
    test_mode_hold();
    test_reset_mid();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
